// File: rtl/fault_campaign_mid_pkg.sv
// Shared types and helpers for the fault-campaign controller: FSM states,
// LFSR tap table and fault index encode/decode.
package fault_campaign_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    // Maximal-length Fibonacci tap masks (bit i = stage i feeds the XOR), widths 3..16.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int fault_site(input int k);
        return k >> 1;
    endfunction

    function automatic logic fault_val(input int k);
        return k[0];
    endfunction

    function automatic int fault_index(input int site, input logic val);
        return site * 2 + int'(val);
    endfunction

endpackage

// File: rtl/fault_campaign_mid_if.sv
// Control, CUT-facing and result signals of the fault-campaign controller.
interface fault_campaign_mid_if #(
    parameter int IN_BITS   = 5,
    parameter int OUT_BITS  = 2,
    parameter int NUM_SITES = 11
);
    localparam int NUM_FAULTS = 2 * NUM_SITES;
    localparam int SW = $clog2(NUM_SITES);
    localparam int CW = $clog2(NUM_FAULTS + 1);

    logic                  START;
    logic                  ABORT;
    logic [IN_BITS-1:0]    TEST_IP;
    logic                  FAULT_EN;
    logic [SW-1:0]         FAULT_SITE;
    logic                  FAULT_VAL;
    logic                  FIL_INC;
    logic [OUT_BITS-1:0]   CUT_OP;
    logic [OUT_BITS-1:0]   FF_OP;
    logic [NUM_FAULTS-1:0] DET_MAP;
    logic [CW-1:0]         DET_COUNT;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        input  START, ABORT, CUT_OP, FF_OP,
        output TEST_IP, FAULT_EN, FAULT_SITE, FAULT_VAL, FIL_INC,
               DET_MAP, DET_COUNT, BUSY, DONE
    );

    modport slave (
        output START, ABORT, CUT_OP, FF_OP,
        input  TEST_IP, FAULT_EN, FAULT_SITE, FAULT_VAL, FIL_INC,
               DET_MAP, DET_COUNT, BUSY, DONE
    );
endinterface

// File: rtl/fcm_pattern_gen.sv
// Pattern source for the campaign: binary up-counter or Fibonacci LFSR,
// restarted per fault and stepped once per compared pattern.
module fcm_pattern_gen
    import fault_campaign_pkg::*;
#(
    parameter int IN_BITS  = 5,
    parameter int PAT_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               step,
    output logic [IN_BITS-1:0] pattern
);
    logic [IN_BITS-1:0] nxt;

    generate
        if (PAT_MODE == 1) begin : g_lfsr
            localparam logic [IN_BITS-1:0] TAPS = IN_BITS'(lfsr_taps(IN_BITS));
            assign nxt = {pattern[IN_BITS-2:0], ^(pattern & TAPS)};
        end else begin : g_cnt
            assign nxt = pattern + 1'b1;
        end
    endgenerate

    // Reset value is zero in both modes; restart loads the real seed before any RUN.
    always_ff @(posedge clk) begin
        if (rst)
            pattern <= '0;
        else if (restart)
            pattern <= (PAT_MODE == 1) ? {IN_BITS{1'b1}} : '0;
        else if (step)
            pattern <= nxt;
    end
endmodule

// File: rtl/fault_campaign_mid.sv
// Fault-simulation controller: walks every stuck-at fault, applies NUM_PAT
// patterns to faulty and fault-free CUTs, and records detection and coverage.
module fault_campaign_mid
    import fault_campaign_pkg::*;
#(
    parameter int IN_BITS   = 5,
    parameter int OUT_BITS  = 2,
    parameter int NUM_SITES = 11,
    parameter int NUM_PAT   = 32,
    parameter int PAT_MODE  = 0,
    parameter int DROP      = 1
) (
    input  logic                clk,
    input  logic                rst,
    fault_campaign_mid_if.master bus
);
    localparam int NUM_FAULTS = 2 * NUM_SITES;
    localparam int KW = $clog2(NUM_FAULTS);
    localparam int SW = $clog2(NUM_SITES);
    localparam int CW = $clog2(NUM_FAULTS + 1);
    localparam int PW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

    state_e                state, state_nx;
    logic [KW-1:0]         k;
    logic [PW-1:0]         p;
    logic [NUM_FAULTS-1:0] det_map;
    logic [CW-1:0]         det_count;
    logic [OUT_BITS-1:0]   diff;
    logic                  mism, last_pat, last_fault;
    logic                  start_c, next_c, step_c, set_det;

    assign diff       = bus.CUT_OP ^ bus.FF_OP;
    assign mism       = |diff;
    assign last_pat   = (p == PW'(NUM_PAT - 1));
    assign last_fault = (k == KW'(NUM_FAULTS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_c  = 1'b0;
        next_c   = 1'b0;
        step_c   = 1'b0;
        set_det  = 1'b0;
        if (bus.ABORT) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.START) begin
                        start_c  = 1'b1;
                        state_nx = LOAD;
                    end
                end
                LOAD: state_nx = RUN;
                RUN: begin
                    set_det = mism;
                    if (last_pat || (DROP != 0 && mism)) begin
                        if (last_fault) begin
                            state_nx = DONE;
                        end else begin
                            next_c   = 1'b1;
                            state_nx = LOAD;
                        end
                    end else begin
                        step_c = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Pattern source restarts on the edge entering LOAD so LOAD already shows pattern 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            k         <= '0;
            p         <= '0;
            det_map   <= '0;
            det_count <= '0;
        end else begin
            if (start_c) begin
                k         <= '0;
                det_map   <= '0;
                det_count <= '0;
            end else if (next_c) begin
                k <= k + 1'b1;
            end
            if (start_c || next_c)
                p <= '0;
            else if (step_c)
                p <= p + 1'b1;
            if (set_det) begin
                det_map[k] <= 1'b1;
                if (!det_map[k])
                    det_count <= det_count + 1'b1;
            end
        end
    end

    fcm_pattern_gen #(
        .IN_BITS  (IN_BITS),
        .PAT_MODE (PAT_MODE)
    ) u_pat (
        .clk     (clk),
        .rst     (rst),
        .restart (start_c || next_c),
        .step    (step_c),
        .pattern (bus.TEST_IP)
    );

    assign bus.FAULT_EN   = (state == LOAD) || (state == RUN);
    assign bus.BUSY       = (state == LOAD) || (state == RUN);
    assign bus.FIL_INC    = (state == LOAD);
    assign bus.DONE       = (state == DONE);
    assign bus.FAULT_SITE = SW'(fault_site(int'(k)));
    assign bus.FAULT_VAL  = fault_val(int'(k));
    assign bus.DET_MAP    = det_map;
    assign bus.DET_COUNT  = det_count;
endmodule

// File: tb/tb_fault_campaign_mid.sv
// Scoreboard bench: stimulus queues expected FIL_INC/DONE events, a negedge
// monitor pops and compares them; three DUTs cover DROP=0, DROP=1 and LFSR mode.
module tb_fault_campaign_mid;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   mode = 0;
    int   sel = 0;
    int   total = 0, passed = 0;
    int   fil_seen = 0, done_evt = 0, start_cyc = 0;
    logic prev_done = 1'b0;

    typedef struct { int site; logic val; logic [4:0] ip; } fil_t;
    typedef struct { int cycles; logic [21:0] map; int cnt; int fil; } done_t;
    fil_t  fil_q[$];
    done_t done_q[$];
    fil_t  fe;
    done_t de;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fault_campaign_mid_if #(.IN_BITS(5), .OUT_BITS(2), .NUM_SITES(11)) a_if ();
    fault_campaign_mid_if #(.IN_BITS(5), .OUT_BITS(2), .NUM_SITES(11)) b_if ();
    fault_campaign_mid_if #(.IN_BITS(5), .OUT_BITS(2), .NUM_SITES(11)) c_if ();

    fault_campaign_mid #(.DROP(0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    fault_campaign_mid #(.DROP(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
    fault_campaign_mid #(.DROP(0), .PAT_MODE(1)) dut_c (.clk(clk), .rst(rst), .bus(c_if));

    function automatic logic [1:0] good_op(input logic [4:0] ip);
        return {ip[4] ^ ip[1], ip[0] & ip[2]};
    endfunction

    // md 0: detect when ip[3:0]==site; md 1: always; md 2: always except fault 6
    function automatic logic flip(input int md, input logic en, input logic [3:0] site,
                                  input logic val, input logic [4:0] ip);
        if (!en) return 1'b0;
        case (md)
            0:       return ip[3:0] == site;
            1:       return 1'b1;
            default: return !(site == 4'd3 && !val);
        endcase
    endfunction

    assign a_if.FF_OP  = good_op(a_if.TEST_IP);
    assign a_if.CUT_OP = good_op(a_if.TEST_IP)
                       ^ {1'b0, flip(mode, a_if.FAULT_EN, a_if.FAULT_SITE, a_if.FAULT_VAL, a_if.TEST_IP)};
    assign b_if.FF_OP  = good_op(b_if.TEST_IP);
    assign b_if.CUT_OP = good_op(b_if.TEST_IP)
                       ^ {1'b0, flip(mode, b_if.FAULT_EN, b_if.FAULT_SITE, b_if.FAULT_VAL, b_if.TEST_IP)};
    assign c_if.FF_OP  = 2'b00;
    assign c_if.CUT_OP = 2'b00;

    logic        m_fil, m_done, m_en, m_val;
    logic [3:0]  m_site;
    logic [4:0]  m_ip, m_cnt;
    logic [21:0] m_map;
    assign m_fil  = (sel == 1) ? b_if.FIL_INC    : a_if.FIL_INC;
    assign m_done = (sel == 1) ? b_if.DONE       : a_if.DONE;
    assign m_en   = (sel == 1) ? b_if.FAULT_EN   : a_if.FAULT_EN;
    assign m_val  = (sel == 1) ? b_if.FAULT_VAL  : a_if.FAULT_VAL;
    assign m_site = (sel == 1) ? b_if.FAULT_SITE : a_if.FAULT_SITE;
    assign m_ip   = (sel == 1) ? b_if.TEST_IP    : a_if.TEST_IP;
    assign m_cnt  = (sel == 1) ? b_if.DET_COUNT  : a_if.DET_COUNT;
    assign m_map  = (sel == 1) ? b_if.DET_MAP    : a_if.DET_MAP;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_in(input int which, input logic s, input logic a);
        case (which)
            0:       begin a_if.START = s; a_if.ABORT = a; end
            1:       begin b_if.START = s; b_if.ABORT = a; end
            default: begin c_if.START = s; c_if.ABORT = a; end
        endcase
    endtask

    task automatic push_fils(input int n);
        fil_t e;
        for (int k = 0; k < n; k++) begin
            e.site = k / 2;
            e.val  = (k % 2) == 1;
            e.ip   = 5'd0;
            fil_q.push_back(e);
        end
    endtask

    // start_cyc marks the edge that samples START
    task automatic go(input int which);
        @(posedge clk); #1;
        fil_seen = 0;
        set_in(which, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_in(which, 1'b0, 1'b0);
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int e0 = done_evt;
        int n  = 0;
        while (done_evt == e0 && n < budget) begin @(posedge clk); n++; end
        #1;
        chk("done_reached", done_evt != e0, 1);
    endtask

    task automatic wait_fil(input int cnt, input int budget);
        int n = 0;
        while (fil_seen < cnt && n < budget) begin @(posedge clk); n++; end
        #1;
        chk("fil_reached", fil_seen >= cnt, 1);
    endtask

    task automatic chk_rst_a(input string pfx);
        chk({pfx, "_test_ip"},    a_if.TEST_IP, 0);
        chk({pfx, "_fault_en"},   a_if.FAULT_EN, 0);
        chk({pfx, "_fault_site"}, a_if.FAULT_SITE, 0);
        chk({pfx, "_fault_val"},  a_if.FAULT_VAL, 0);
        chk({pfx, "_fil_inc"},    a_if.FIL_INC, 0);
        chk({pfx, "_det_map"},    a_if.DET_MAP, 0);
        chk({pfx, "_det_count"},  a_if.DET_COUNT, 0);
        chk({pfx, "_busy"},       a_if.BUSY, 0);
        chk({pfx, "_done"},       a_if.DONE, 0);
    endtask

    // Monitor: compare each FIL_INC pulse and each DONE rise against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_fil) begin
                    fil_seen++;
                    chk("fil_expected", fil_q.size() != 0, 1);
                    if (fil_q.size() != 0) begin
                        fe = fil_q.pop_front();
                        chk("fil_site", m_site, fe.site);
                        chk("fil_val", m_val, fe.val);
                        chk("fil_en", m_en, 1);
                        chk("fil_first_pat", m_ip, fe.ip);
                    end
                end
                if (m_done && !prev_done) begin
                    done_evt++;
                    chk("done_expected", done_q.size() != 0, 1);
                    if (done_q.size() != 0) begin
                        de = done_q.pop_front();
                        chk("done_cycles", cyc - start_cyc, de.cycles);
                        chk("done_det_map", m_map, de.map);
                        chk("done_det_count", m_cnt, de.cnt);
                        chk("done_fil_pulses", fil_seen, de.fil);
                    end
                end
            end
            prev_done = m_done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] pats[32];
        int n, ones;
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        set_in(2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_rst_a("por");

        // DROP=0, every fault detected twice (ip[3:0]==site at p=site and site+16)
        sel = 0; mode = 0;
        push_fils(22);
        done_q.push_back('{726, 22'h3FFFFF, 22, 22});
        go(0);
        wait_done(1000);
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", a_if.DONE, 1);
        chk("map_held", a_if.DET_MAP, 22'h3FFFFF);
        chk("done_fault_en", a_if.FAULT_EN, 0);

        // Reset in the middle of fault 5's RUN
        push_fils(6);
        go(0);
        wait_fil(6, 400);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_count", a_if.DET_COUNT, 6);
        chk("pre_rst_busy", a_if.BUSY, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_rst_a("mid_rst");
        rst = 1'b0;
        chk("fil_q_drained_rst", fil_q.size(), 0);

        // DROP=1, every fault caught on its first pattern; a START mid-run is ignored
        sel = 1; mode = 1;
        push_fils(22);
        done_q.push_back('{44, 22'h3FFFFF, 22, 22});
        go(1);
        wait_fil(10, 100);
        @(posedge clk); #1 set_in(1, 1'b1, 1'b0);
        @(posedge clk); #1 set_in(1, 1'b0, 1'b0);
        wait_done(200);

        // Fault 6 (site 3, s-a-0) redundant: it runs all 32 patterns
        mode = 2;
        push_fils(22);
        done_q.push_back('{75, 22'h3FFFBF, 21, 22});
        go(1);
        wait_done(300);

        // ABORT during fault 3's LOAD, results kept
        mode = 1;
        push_fils(4);
        go(1);
        n = 0;
        while (!(b_if.FIL_INC && b_if.FAULT_SITE == 4'd1 && b_if.FAULT_VAL) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        set_in(1, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0);
        chk("abort_busy", b_if.BUSY, 0);
        chk("abort_fault_en", b_if.FAULT_EN, 0);
        chk("abort_done", b_if.DONE, 0);
        chk("abort_map", b_if.DET_MAP, 22'h000007);
        chk("abort_count", b_if.DET_COUNT, 3);
        chk("fil_q_drained_abort", fil_q.size(), 0);

        // Restart after abort clears results and begins at k=0
        push_fils(22);
        done_q.push_back('{44, 22'h3FFFFF, 22, 22});
        go(1);
        chk("restart_map_clr", b_if.DET_MAP, 0);
        chk("restart_count_clr", b_if.DET_COUNT, 0);
        chk("restart_busy", b_if.BUSY, 1);
        wait_done(200);

        // START and ABORT together in DONE: abort wins, nothing starts
        @(posedge clk); #1 set_in(1, 1'b1, 1'b1);
        @(posedge clk); #1 set_in(1, 1'b0, 1'b0);
        chk("sa_busy", b_if.BUSY, 0);
        chk("sa_done", b_if.DONE, 0);
        chk("sa_fil", b_if.FIL_INC, 0);
        chk("sa_map", b_if.DET_MAP, 22'h3FFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sa_still_idle", b_if.BUSY, 0);

        // LFSR mode: 1F,1E,1C,18,11,... period 31, 31st pattern 0F
        go(2);
        chk("lfsr_load_pat", c_if.TEST_IP, 5'h1F);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            pats[i] = c_if.TEST_IP;
        end
        chk("lfsr_p1", pats[0], 5'h1F);
        chk("lfsr_p2", pats[1], 5'h1E);
        chk("lfsr_p3", pats[2], 5'h1C);
        chk("lfsr_p4", pats[3], 5'h18);
        chk("lfsr_p5", pats[4], 5'h11);
        chk("lfsr_p31", pats[30], 5'h0F);
        chk("lfsr_p32", pats[31], 5'h1F);
        ones = 0;
        for (int i = 0; i < 32; i++) if (pats[i] == 5'h1F) ones++;
        chk("lfsr_period", ones, 2);
        @(posedge clk); #1 set_in(2, 1'b0, 1'b1);
        @(posedge clk); #1 set_in(2, 1'b0, 1'b0);
        chk("lfsr_abort_busy", c_if.BUSY, 0);

        chk("fil_q_empty", fil_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
